// File: rtl/eclk_sync_seq.sv
// Purpose: edge-clock resync sequencer -- qualifies PLL lock, stops the edge clock, pulses datapath reset, restarts and checks word alignment with bounded retries.
// Latency: lock reaches the FSM after 2 eclk; all outputs are registered and change on the same edge the state register enters a state.
// Backpressure: none; update_req is honoured only in READY/FAIL and dropped elsewhere, lock loss overrides everything.
module eclk_sync_seq #(
    parameter int LOCK_FILT     = 16,
    parameter int STOP_CYCLES   = 8,
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 32,
    parameter int MAX_RETRY     = 3
) (
    input  logic       eclk,
    input  logic       reset,
    input  logic       lock,
    input  logic       update_req,
    input  logic       align_ok,
    output logic       pll_stop,
    output logic       reset_datapath,
    output logic       ready,
    output logic       fail,
    output logic [3:0] attempts
);

    localparam logic [7:0] L_FILT       = 8'(LOCK_FILT);
    localparam logic [7:0] L_STOP_LAST  = 8'(STOP_CYCLES - 1);
    localparam logic [7:0] L_RST_LAST   = 8'(RST_CYCLES - 1);
    localparam logic [7:0] L_SETL_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] L_RETRY      = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_STOP,
        S_RST,
        S_REL,
        S_SETTLE,
        S_CHECK,
        S_READY,
        S_FAIL
    } state_t;

    logic       r_lock_m;
    logic       r_lock_s;
    logic [7:0] r_filt;
    logic [7:0] w_filt_nxt;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_timer;
    logic [7:0] w_timer_nxt;
    logic [3:0] r_att;
    logic [3:0] w_att_nxt;
    logic       r_pll_stop;
    logic       r_reset_dp;
    logic       r_ready;
    logic       r_fail;
    logic       w_pll_stop;
    logic       w_reset_dp;
    logic       w_ready;
    logic       w_fail;

    // Two-flop synchronizer: lock is asynchronous to eclk.
    always_ff @(posedge eclk or posedge reset) begin
        if (reset) begin
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_lock_m <= lock;
            r_lock_s <= r_lock_m;
        end
    end

    // Lock filter: counts consecutive synchronized-high cycles, saturating at LOCK_FILT.
    always_comb begin
        w_filt_nxt = 8'd0;
        if (r_lock_s) begin
            w_filt_nxt = (r_filt == L_FILT) ? r_filt : r_filt + 8'd1;
        end
    end

    // Lock filter register.
    always_ff @(posedge eclk or posedge reset) begin
        if (reset) begin
            r_filt <= 8'd0;
        end else begin
            r_filt <= w_filt_nxt;
        end
    end

    // Next-state, timer and retry counter; lock loss outranks every other decision.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = 8'd0;
        w_att_nxt   = r_att;
        if (r_state != S_WAIT_LOCK && !r_lock_s) begin
            w_state_nxt = S_WAIT_LOCK;
            w_att_nxt   = 4'd0;
        end else begin
            unique case (r_state)
                S_WAIT_LOCK: begin
                    // Leave on the very edge the filter reaches its target.
                    if (w_filt_nxt == L_FILT) begin
                        w_state_nxt = S_STOP;
                    end
                end
                S_STOP: begin
                    if (r_timer == L_STOP_LAST) begin
                        w_state_nxt = S_RST;
                    end else begin
                        w_timer_nxt = r_timer + 8'd1;
                    end
                end
                S_RST: begin
                    if (r_timer == L_RST_LAST) begin
                        w_state_nxt = S_REL;
                    end else begin
                        w_timer_nxt = r_timer + 8'd1;
                    end
                end
                S_REL: begin
                    if (r_timer == L_STOP_LAST) begin
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_timer_nxt = r_timer + 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (r_timer == L_SETL_LAST) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_timer_nxt = r_timer + 8'd1;
                    end
                end
                S_CHECK: begin
                    if (align_ok) begin
                        w_state_nxt = S_READY;
                    end else begin
                        w_att_nxt   = r_att + 4'd1;
                        w_state_nxt = (w_att_nxt == L_RETRY) ? S_FAIL : S_STOP;
                    end
                end
                S_READY, S_FAIL: begin
                    if (update_req) begin
                        w_state_nxt = S_STOP;
                        w_att_nxt   = 4'd0;
                    end
                end
            endcase
        end
    end

    // Output decode from the next state so registered outputs line up with the state register.
    always_comb begin
        w_pll_stop = 1'b0;
        w_reset_dp = 1'b0;
        w_ready    = 1'b0;
        w_fail     = 1'b0;
        unique case (w_state_nxt)
            S_WAIT_LOCK: begin
                w_pll_stop = 1'b1;
                w_reset_dp = 1'b1;
            end
            S_STOP, S_REL: begin
                w_pll_stop = 1'b1;
            end
            S_RST: begin
                w_pll_stop = 1'b1;
                w_reset_dp = 1'b1;
            end
            S_SETTLE, S_CHECK: begin
                w_pll_stop = 1'b0;
            end
            S_READY: begin
                w_ready = 1'b1;
            end
            S_FAIL: begin
                w_fail = 1'b1;
            end
        endcase
    end

    // State, timer, retry count and registered outputs.
    always_ff @(posedge eclk or posedge reset) begin
        if (reset) begin
            r_state    <= S_WAIT_LOCK;
            r_timer    <= 8'd0;
            r_att      <= 4'd0;
            r_pll_stop <= 1'b1;
            r_reset_dp <= 1'b1;
            r_ready    <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_att      <= w_att_nxt;
            r_pll_stop <= w_pll_stop;
            r_reset_dp <= w_reset_dp;
            r_ready    <= w_ready;
            r_fail     <= w_fail;
        end
    end

    assign pll_stop       = r_pll_stop;
    assign reset_datapath = r_reset_dp;
    assign ready          = r_ready;
    assign fail           = r_fail;
    assign attempts       = r_att;

endmodule
